// File: rtl/multicycle_adder.sv
// multicycle_adder: two's-complement add/subtract that processes CHUNK bits per
// clock, least-significant chunk first, so a WIDTH-bit result takes
// WIDTH/CHUNK RUN cycles. Results and flags are published atomically on the
// edge that finishes the last chunk and hold until the next completion.
// WIDTH must be an integer multiple of CHUNK.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int C     = WIDTH / CHUNK;
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(C - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Captured operands; b_q already holds the effective B (inverted for subtract).
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Partial result: chunks below cnt_q are final, chunks above are still zero.
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] part_nxt;
  // Running carry between chunks; seeded with sub to complete the two's complement.
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  assign last_chunk = (cnt_q == LAST_CHUNK);

  // One CHUNK+1 bit addition of the current chunk pair plus running carry,
  // merged into a copy of the partial result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    chunk_sum = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
              + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    part_nxt  = part_q;
    part_nxt[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and handshake decode; busy and done come straight from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and atomic publication of the result.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is a handful of flops, not a memory, so all of it is cleared on reset to give a clean abort.
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      out      <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= aIn;
            b_q     <= sub ? ~bIn : bIn;
            carry_q <= sub;
            cnt_q   <= '0;
            part_q  <= '0;
          end
        end
        RUN: begin
          part_q  <= part_nxt;
          carry_q <= chunk_sum[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            out      <= part_nxt;
            carryOut <= chunk_sum[CHUNK];
            // Same-sign operands producing a result of the other sign.
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (part_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero     <= (part_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: a 16/4 instance for the handshake, abort and
// random arithmetic checks, plus 32/8 and 32/32 instances for latency scaling.
// Expected results come from plain integer arithmetic on the operands.
module tb_multicycle_adder;

  logic clk;
  logic reset;

  // 16-bit, 4-bit chunk instance
  logic        start16, sub16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] out16;
  logic        carry16, ovf16, zero16;

  // 32-bit instances sharing operand inputs
  logic        start8, start32, sub32;
  logic [31:0] a32, b32;
  logic        busy8, done8, carry8, ovf8, zero8;
  logic [31:0] out8;
  logic        busyw, donew, carryw, ovfw, zerow;
  logic [31:0] outw;

  int vectors;
  int miscompares;
  logic [15:0] last_out16;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_add16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16),
    .aIn(a16), .bIn(b16), .busy(busy16), .done(done16), .out(out16),
    .carryOut(carry16), .overflow(ovf16), .zero(zero16)
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_add32_c8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub32),
    .aIn(a32), .bIn(b32), .busy(busy8), .done(done8), .out(out8),
    .carryOut(carry8), .overflow(ovf8), .zero(zero8)
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_add32_c32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32),
    .aIn(a32), .bIn(b32), .busy(busyw), .done(donew), .out(outw),
    .carryOut(carryw), .overflow(ovfw), .zero(zerow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result of a+b or a-b modulo 2^w, unsigned carry (no-borrow for
  // subtract) and signed overflow from the true mathematical result.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit s, output longint unsigned r,
                                output bit c, output bit v, output bit z);
    longint unsigned m = 64'd1 << w;
    longint sa, sb, t;
    sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    if (s) begin
      r = (a + m - b) % m;
      c = (a >= b);
      t = sa - sb;
    end else begin
      r = (a + b) % m;
      c = ((a + b) >= m);
      t = sa + sb;
    end
    v = (t >= longint'(m / 2)) || (t < -longint'(m / 2));
    z = (r == 0);
  endfunction

  // Full operation on the 16-bit instance with exact timing checks; operands
  // are scrambled while running to show they were captured at start.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
    longint unsigned r;
    bit c, v, z;
    model(16, a, b, s, r, c, v, z);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; sub16 = s;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      check({tag, "/busy"}, busy16, 1);
      check({tag, "/done_early"}, done16, 0);
      check({tag, "/out_hold"}, out16, last_out16);
    end
    @(negedge clk);
    check({tag, "/done"}, done16, 1);
    check({tag, "/busy_done"}, busy16, 0);
    check({tag, "/out"}, out16, r[15:0]);
    check({tag, "/carry"}, carry16, c);
    check({tag, "/ovf"}, ovf16, v);
    check({tag, "/zero"}, zero16, z);
    @(negedge clk);
    check({tag, "/done_pulse"}, done16, 0);
    check({tag, "/out_after"}, out16, r[15:0]);
    last_out16 = r[15:0];
  endtask

  // Operation on one of the 32-bit instances; measures edges from start to done.
  task automatic op32(input bit wide, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input string tag);
    longint unsigned r;
    bit c, v, z;
    int n;
    int lat;
    logic dn, bz, oc, ov, oz;
    logic [31:0] ores;
    lat = wide ? 1 : 4;
    model(32, a, b, s, r, c, v, z);
    @(negedge clk);
    a32 = a; b32 = b; sub32 = s;
    if (wide) start32 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; start8 = 1'b0;
    bz = wide ? busyw : busy8;
    check({tag, "/busy"}, bz, 1);
    n  = 0;
    dn = wide ? donew : done8;
    while (!dn && n < 10) begin
      @(negedge clk);
      n++;
      dn = wide ? donew : done8;
    end
    check({tag, "/latency"}, n, lat);
    ores = wide ? outw : out8;
    oc   = wide ? carryw : carry8;
    ov   = wide ? ovfw : ovf8;
    oz   = wide ? zerow : zero8;
    check({tag, "/out"}, ores, r[31:0]);
    check({tag, "/carry"}, oc, c);
    check({tag, "/ovf"}, ov, v);
    check({tag, "/zero"}, oz, z);
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    last_out16 = '0;
    reset = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/busy", busy16, 0);
    check("reset/done", done16, 0);
    check("reset/out", out16, 0);
    check("reset/flags", {carry16, ovf16, zero16}, 0);
    check("reset/busy32", {busy8, busyw, done8, donew}, 0);
    reset = 1'b0;

    // Directed arithmetic cases
    op16(16'd15, 16'd15, 1'b0, "add15_15");
    op16(16'hFFFB, 16'd12, 1'b0, "neg5_plus12");
    op16(16'd15, 16'd15, 1'b1, "sub15_15");
    op16(16'h7FFF, 16'd1, 1'b0, "pos_ovf");
    op16(16'h8000, 16'd1, 1'b1, "neg_ovf");
    op16(16'd3, 16'd5, 1'b1, "borrow");

    // start held through RUN is ignored; start in DONE begins a new operation
    @(negedge clk);
    start16 = 1'b1; a16 = 16'd15; b16 = 16'd15; sub16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      check("b2b/run_busy", busy16, 1);
      check("b2b/run_nodone", done16, 0);
    end
    @(negedge clk);
    check("b2b/done1", done16, 1);
    check("b2b/out1", out16, 16'd30);
    a16 = 16'd1; b16 = 16'd1; sub16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 10) begin
      @(negedge clk);
      n++;
    end
    // Counted from the first DONE cycle: one edge into RUN, four chunk edges.
    check("b2b/gap", n + 1, 5);
    check("b2b/out2", out16, 16'd2);
    last_out16 = 16'd2;
    @(negedge clk);
    check("b2b/idle", {busy16, done16}, 0);

    // Reset during the second RUN cycle aborts with no done pulse
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    check("abort/in_run", busy16, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort/busy", busy16, 0);
    check("abort/out", out16, 0);
    check("abort/done", done16, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done16 || busy16) n++;
    end
    check("abort/quiet", n, 0);
    last_out16 = '0;
    op16(16'h1234, 16'h1111, 1'b0, "after_abort");

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
    end

    // Wider instances: C=4 and C=1
    op32(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "c8_wrap");
    op32(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, "c32_wrap");
    for (int i = 0; i < 6; i++) begin
      op32(1'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), "rand32");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
